rv32i_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the register file.
- Reads the architectural PC from the register file's pc_out and issues single-outstanding requests on a req/gnt/rvld instruction-memory bus.
- Buffers one fetched instruction toward decode and writes the next PC back into the register file's PC port (pc_in / pc_in_vld).
- Handles branch/jump redirects from execute, including killing an in-flight fetch, and traps fetch faults.

---
 rtl/rv32i_fetch_if.sv | 28 ++
 rtl/rv32i_fetch.sv | 201 ++++++++++++++++++++
 tb/tb_rv32i_fetch.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
// Single outstanding request: req/gnt handshake, then one rvld beat.
interface rv32i_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvld;
    logic [31:0] imem_rdata;
    logic        imem_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvld,
        input  imem_rdata,
        input  imem_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvld,
        output imem_rdata,
        output imem_err
    );
endinterface

// File: rtl/rv32i_fetch.sv
// RV32I fetch stage: single-outstanding imem fetch, one-entry buffer to decode,
// next-PC write-back to the register file, redirect/kill handling and fault trap.
module rv32i_fetch #(
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_en,
    input  logic [31:0]         pc_cur,
    output logic [31:0]         pc_nxt,
    output logic                pc_nxt_vld,
    input  logic                redirect_vld,
    input  logic [31:0]         redirect_pc,
    rv32i_fetch_if.master       imem,
    output logic                inst_vld,
    output logic [31:0]         inst,
    output logic [31:0]         inst_pc,
    input  logic                inst_rdy,
    output logic                fault,
    output logic [31:0]         fault_pc
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StReq   = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StHold  = 3'd3;
    localparam logic [2:0] StFault = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        req_q, req_d;
    logic        kill_q, kill_d;
    logic        inst_vld_q, inst_vld_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] pc_nxt_q, pc_nxt_d;
    logic        pc_nxt_vld_q, pc_nxt_vld_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] pc_fwd;

    // The regfile takes pc_nxt one edge after the strobe, so forward an in-flight
    // write instead of latching a stale pc_cur.
    assign pc_fwd = pc_nxt_vld_q ? pc_nxt_q : pc_cur;

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        req_d        = req_q;
        kill_d       = kill_q;
        inst_vld_d   = inst_vld_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        pc_nxt_d     = pc_nxt_q;
        pc_nxt_vld_d = 1'b0;
        fault_d      = fault_q;
        fault_pc_d   = fault_pc_q;

        if (state_q != StFault && redirect_vld) begin
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = StFault;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
                req_d      = 1'b0;
                kill_d     = 1'b0;
                inst_vld_d = 1'b0;
                inst_d     = NOP_INST;
            end else begin
                pc_nxt_d     = redirect_pc;
                pc_nxt_vld_d = 1'b1;
                case (state_q)
                    StReq: begin
                        // A pending request is never withdrawn; its response is killed.
                        kill_d = 1'b1;
                        if (imem.imem_gnt) begin
                            req_d   = 1'b0;
                            state_d = StWait;
                        end
                    end
                    StWait: begin
                        if (imem.imem_rvld) begin
                            kill_d = 1'b0;
                            if (fetch_en) begin
                                state_d    = StReq;
                                req_d      = 1'b1;
                                req_addr_d = redirect_pc;
                            end else begin
                                state_d = StIdle;
                            end
                        end else begin
                            kill_d = 1'b1;
                        end
                    end
                    StHold: begin
                        inst_vld_d = 1'b0;
                        inst_d     = NOP_INST;
                        state_d    = StReq;
                        req_d      = 1'b1;
                        req_addr_d = redirect_pc;
                    end
                    default: ;
                endcase
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (fetch_en) begin
                        state_d    = StReq;
                        req_d      = 1'b1;
                        req_addr_d = pc_fwd;
                    end
                end
                StReq: begin
                    if (imem.imem_gnt) begin
                        req_d   = 1'b0;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (imem.imem_rvld) begin
                        if (kill_q) begin
                            kill_d = 1'b0;
                            if (fetch_en) begin
                                state_d    = StReq;
                                req_d      = 1'b1;
                                req_addr_d = pc_fwd;
                            end else begin
                                state_d = StIdle;
                            end
                        end else if (imem.imem_err) begin
                            state_d    = StFault;
                            fault_d    = 1'b1;
                            fault_pc_d = req_addr_q;
                        end else begin
                            inst_vld_d   = 1'b1;
                            inst_d       = imem.imem_rdata;
                            inst_pc_d    = req_addr_q;
                            pc_nxt_d     = req_addr_q + PC_STEP;
                            pc_nxt_vld_d = 1'b1;
                            state_d      = StHold;
                        end
                    end
                end
                StHold: begin
                    if (inst_rdy) begin
                        inst_vld_d = 1'b0;
                        inst_d     = NOP_INST;
                        if (fetch_en) begin
                            state_d    = StReq;
                            req_d      = 1'b1;
                            req_addr_d = pc_fwd;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_addr_q   <= 32'd0;
            req_q        <= 1'b0;
            kill_q       <= 1'b0;
            inst_vld_q   <= 1'b0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= 32'd0;
            pc_nxt_q     <= 32'd0;
            pc_nxt_vld_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_pc_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            req_q        <= req_d;
            kill_q       <= kill_d;
            inst_vld_q   <= inst_vld_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            pc_nxt_q     <= pc_nxt_d;
            pc_nxt_vld_q <= pc_nxt_vld_d;
            fault_q      <= fault_d;
            fault_pc_q   <= fault_pc_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = req_addr_q;
    assign pc_nxt         = pc_nxt_q;
    assign pc_nxt_vld     = pc_nxt_vld_q;
    assign inst_vld       = inst_vld_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fault          = fault_q;
    assign fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Bench for rv32i_fetch: behavioural imem, regfile PC model and scoreboards of
// expected delivered instructions and PC write-backs.
module tb_rv32i_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] pc_cur;
    logic [31:0] pc_nxt;
    logic        pc_nxt_vld;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        inst_vld;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_rdy;
    logic        fault;
    logic [31:0] fault_pc;

    logic        pc_set;
    logic [31:0] pc_set_val;

    rv32i_fetch_if imem ();

    rv32i_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .pc_cur       (pc_cur),
        .pc_nxt       (pc_nxt),
        .pc_nxt_vld   (pc_nxt_vld),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .imem         (imem.master),
        .inst_vld     (inst_vld),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_rdy     (inst_rdy),
        .fault        (fault),
        .fault_pc     (fault_pc)
    );

    always #5 clk = ~clk;

    // Register-file PC: written one edge after the strobe.
    always @(posedge clk) begin
        if (pc_set) pc_cur <= pc_set_val;
        else if (pc_nxt_vld) pc_cur <= pc_nxt;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          cycle_cnt = 0;
    int          req_in_fault = 0;
    logic [31:0] sb_inst[$];
    logic [31:0] sb_pc[$];
    logic [31:0] grants[$];
    int          acc_cyc[$];
    logic        rsp_pending;
    logic [31:0] rsp_addr;
    logic        auto_rsp;
    logic        gnt_hold;
    logic [31:0] err_addr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        logic [31:0] e;
        if (imem.imem_req && imem.imem_gnt) begin
            grants.push_back(imem.imem_addr);
            rsp_addr    = imem.imem_addr;
            rsp_pending = 1'b1;
        end
        if (fault && imem.imem_req) req_in_fault++;
        if (inst_vld && inst_rdy) begin
            chk("inst_expected", 32'(sb_inst.size() != 0), 32'd1);
            if (sb_inst.size() != 0) begin
                e = sb_inst.pop_front();
                chk("inst_pc", inst_pc, e);
                chk("inst", inst, mem_data(e));
            end
            acc_cyc.push_back(cycle_cnt);
        end
        if (pc_nxt_vld) begin
            chk("pc_nxt_expected", 32'(sb_pc.size() != 0), 32'd1);
            if (sb_pc.size() != 0) begin
                e = sb_pc.pop_front();
                chk("pc_nxt", pc_nxt, e);
            end
        end
    endtask

    // One clock: observe at negedge, then update the memory responder after the edge.
    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cycle_cnt++;
        if (imem.imem_rvld) begin
            imem.imem_rvld = 1'b0;
            imem.imem_err  = 1'b0;
        end
        if (rsp_pending && auto_rsp) begin
            imem.imem_rvld  = 1'b1;
            imem.imem_rdata = mem_data(rsp_addr);
            imem.imem_err   = (rsp_addr == err_addr);
            rsp_pending     = 1'b0;
        end
        imem.imem_gnt = imem.imem_req && !gnt_hold;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_pc_nxt"}, pc_nxt, 32'd0);
        chk({p, "_pc_nxt_vld"}, 32'(pc_nxt_vld), 32'd0);
        chk({p, "_imem_req"}, 32'(imem.imem_req), 32'd0);
        chk({p, "_imem_addr"}, imem.imem_addr, 32'd0);
        chk({p, "_inst_vld"}, 32'(inst_vld), 32'd0);
        chk({p, "_inst"}, inst, NOP);
        chk({p, "_inst_pc"}, inst_pc, 32'd0);
        chk({p, "_fault"}, 32'(fault), 32'd0);
        chk({p, "_fault_pc"}, fault_pc, 32'd0);
    endtask

    task automatic start_test(input logic [31:0] pc);
        fetch_en        = 1'b0;
        redirect_vld    = 1'b0;
        inst_rdy        = 1'b1;
        auto_rsp        = 1'b1;
        gnt_hold        = 1'b0;
        rsp_pending     = 1'b0;
        imem.imem_rvld  = 1'b0;
        imem.imem_err   = 1'b0;
        imem.imem_gnt   = 1'b0;
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        pc_set = 1'b1;
        pc_set_val = pc;
        cyc();
        pc_set = 1'b0;
        sb_inst.delete();
        sb_pc.delete();
        grants.delete();
        acc_cyc.delete();
        req_in_fault = 0;
    endtask

    task automatic end_test(input string tag);
        chk({tag, "_sb_inst_left"}, 32'(sb_inst.size()), 32'd0);
        chk({tag, "_sb_pc_left"}, 32'(sb_pc.size()), 32'd0);
    endtask

    task automatic wait_grants(input int n, input string tag);
        for (int i = 0; i < 30 && grants.size() < n; i++) cyc();
        chk({tag, "_grant_timeout"}, 32'(grants.size() >= n), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] a);
        redirect_vld = 1'b1;
        redirect_pc  = a;
        cyc();
        redirect_vld = 1'b0;
    endtask

    logic [31:0] saved_inst, saved_pc;

    initial begin
        pc_set = 1'b0;
        pc_set_val = 32'd0;
        redirect_pc = 32'd0;
        imem.imem_rdata = 32'd0;
        err_addr = 32'hFFFF_FFFF;

        // Reset state, then sequential fetch at full rate.
        start_test(32'h100);
        check_reset_vals("rst");
        sb_inst = '{32'h100, 32'h104, 32'h108, 32'h10C};
        sb_pc   = '{32'h104, 32'h108, 32'h10C, 32'h110};
        fetch_en = 1'b1;
        for (int i = 0; i < 40 && acc_cyc.size() < 3; i++) cyc();
        fetch_en = 1'b0;
        run(8);
        chk("seq_accepts", 32'(acc_cyc.size()), 32'd4);
        if (acc_cyc.size() >= 3) begin
            chk("seq_rate01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("seq_rate12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end
        end_test("seq");

        // Backpressure: buffer and bus stay quiet until decode accepts.
        start_test(32'h500);
        sb_inst = '{32'h500};
        sb_pc   = '{32'h504};
        inst_rdy = 1'b0;
        fetch_en = 1'b1;
        for (int i = 0; i < 20 && !inst_vld; i++) cyc();
        chk("bp_inst_vld", 32'(inst_vld), 32'd1);
        fetch_en = 1'b0;
        saved_inst = inst;
        saved_pc = inst_pc;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_inst_stable", inst, saved_inst);
            chk("bp_pc_stable", inst_pc, saved_pc);
            chk("bp_no_req", 32'(imem.imem_req), 32'd0);
        end
        inst_rdy = 1'b1;
        run(6);
        chk("bp_after_vld", 32'(inst_vld), 32'd0);
        end_test("bp");

        // Redirect while the 0x200 response is outstanding.
        start_test(32'h200);
        sb_inst = '{32'h400};
        sb_pc   = '{32'h400, 32'h404};
        auto_rsp = 1'b0;
        fetch_en = 1'b1;
        wait_grants(1, "rw");
        redirect(32'h400);
        auto_rsp = 1'b1;
        wait_grants(2, "rw");
        fetch_en = 1'b0;
        run(8);
        if (grants.size() >= 2) chk("rw_next_addr", grants[1], 32'h400);
        end_test("rw");

        // Redirect in the same cycle as an erroring response: dropped, no fault.
        start_test(32'h200);
        sb_inst = '{32'h400};
        sb_pc   = '{32'h400, 32'h404};
        auto_rsp = 1'b0;
        fetch_en = 1'b1;
        wait_grants(1, "rs");
        rsp_pending     = 1'b0;
        imem.imem_rvld  = 1'b1;
        imem.imem_rdata = mem_data(32'h200);
        imem.imem_err   = 1'b1;
        redirect(32'h400);
        auto_rsp = 1'b1;
        chk("rs_no_fault", 32'(fault), 32'd0);
        wait_grants(2, "rs");
        fetch_en = 1'b0;
        run(8);
        if (grants.size() >= 2) chk("rs_next_addr", grants[1], 32'h400);
        chk("rs_no_fault_end", 32'(fault), 32'd0);
        end_test("rs");

        // Redirect while the grant is held off: the request stays put.
        start_test(32'h200);
        sb_inst = '{32'h400};
        sb_pc   = '{32'h400, 32'h404};
        gnt_hold = 1'b1;
        fetch_en = 1'b1;
        for (int i = 0; i < 10 && !imem.imem_req; i++) cyc();
        redirect(32'h400);
        chk("rg_req_held", 32'(imem.imem_req), 32'd1);
        chk("rg_addr_held", imem.imem_addr, 32'h200);
        run(2);
        chk("rg_addr_still", imem.imem_addr, 32'h200);
        gnt_hold = 1'b0;
        wait_grants(2, "rg");
        fetch_en = 1'b0;
        run(8);
        if (grants.size() >= 2) begin
            chk("rg_first_addr", grants[0], 32'h200);
            chk("rg_next_addr", grants[1], 32'h400);
        end
        end_test("rg");

        // Bus error: sticky fault, no further requests, redirects ignored.
        start_test(32'h300);
        err_addr = 32'h300;
        fetch_en = 1'b1;
        run(8);
        chk("be_fault", 32'(fault), 32'd1);
        chk("be_fault_pc", fault_pc, 32'h300);
        redirect(32'h800);
        run(4);
        chk("be_fault_pc_kept", fault_pc, 32'h300);
        chk("be_req_in_fault", 32'(req_in_fault), 32'd0);
        chk("be_grants", 32'(grants.size()), 32'd1);
        end_test("be");
        err_addr = 32'hFFFF_FFFF;
        start_test(32'h0);
        chk("be_rst_clears", 32'(fault), 32'd0);

        // Misaligned redirect traps without a PC write.
        start_test(32'h600);
        redirect(32'h402);
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_fault_pc", fault_pc, 32'h402);
        chk("mis_no_pc_vld", 32'(pc_nxt_vld), 32'd0);
        run(3);
        end_test("mis");

        // Next-PC wraps at the top of the address space.
        start_test(32'hFFFF_FFFC);
        sb_inst = '{32'hFFFF_FFFC};
        sb_pc   = '{32'h0};
        fetch_en = 1'b1;
        wait_grants(1, "wrap");
        fetch_en = 1'b0;
        run(6);
        end_test("wrap");

        // Reset in WAIT, late response afterwards must be ignored.
        start_test(32'h700);
        auto_rsp = 1'b0;
        fetch_en = 1'b1;
        wait_grants(1, "lr");
        fetch_en = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        auto_rsp = 1'b1;
        run(4);
        check_reset_vals("lr");
        end_test("lr");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
